// File: rtl/serial_sub_behavioral_if.sv
// ============================================================================
// Module      : serial_sub_behavioral_if
// Description : Request/result bundle for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_sub_behavioral_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

`default_nettype wire

// File: rtl/serial_sub_behavioral.sv
// ============================================================================
// Module      : serial_sub_behavioral
// Description : Bit-serial a - b - borrow_in, LSB first, one full-subtractor
//               cell plus a borrow flip-flop. WIDTH+2 cycles per operation.
//               Optional signed overflow flag: SERIAL_SUB_OVERFLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub_behavioral #(
    parameter int WIDTH = 8
) (
    input  wire                     clk,
    input  wire                     rst,
    serial_sub_behavioral_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_part;
    logic [CNT_W-1:0] r_cnt;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_part_next;
    logic             w_accept;
    logic             w_last;

    // Full-subtractor cell
    assign w_x         = r_a_sh[0];
    assign w_y         = r_b_sh[0];
    assign w_d         = w_x ^ w_y ^ r_br;
    assign w_br_next   = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    assign w_part_next = WIDTH'({w_d, r_part} >> 1);

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = (r_state == RUN) && (r_cnt == c_last_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_cnt == c_last_cnt) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_part       <= '0;
            r_cnt        <= '0;
            r_br         <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= bus.a;
            r_b_sh <= bus.b;
            r_part <= '0;
            r_cnt  <= '0;
            r_br   <= bus.borrow_in;
        end else if (r_state == RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_part <= w_part_next;
            r_cnt  <= r_cnt + 1'b1;
            r_br   <= w_br_next;
            if (w_last) begin
                r_diff       <= w_part_next;
                r_borrow_out <= w_br_next;
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_overflow;

    // Operand MSBs are kept separately because the shift registers drain them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
        end else if (w_last) begin
            r_overflow <= (r_a_msb != r_b_msb) && (w_part_next[WIDTH-1] != r_a_msb);
        end
    end

    assign bus.overflow = r_overflow;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;

endmodule

`default_nettype wire
